// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared combinational ALU.
// Grants one operation, holds its operands on the ALU for a cycle, registers the result and returns it tagged with the requester id.
module alu_arbiter #(
    parameter int DATA_W = 2,
    parameter int SEL_W  = 4,
    parameter int RES_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [SEL_W-1:0]  req0_sel,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [SEL_W-1:0]  req1_sel,
    output logic              req1_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [RES_W-1:0]  alu_out,
    input  logic              alu_carry,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [RES_W-1:0]  rsp_result,
    output logic              rsp_carry,
    input  logic              rsp_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              id_q, id_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [SEL_W-1:0]  op_sel_q, op_sel_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [RES_W-1:0]  rsp_result_q, rsp_result_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic              busy_q, busy_d;
    logic              any_valid_s;
    logic              pick_s;

    // Requester 1 wins when it is alone, or on contention when requester 0 had the last grant.
    assign any_valid_s = req0_valid | req1_valid;
    assign pick_s      = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;

    // Next-state, grant and capture logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_sel_d     = op_sel_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid_s && !reset) begin
                    req0_ready   = ~pick_s;
                    req1_ready   = pick_s;
                    op_a_d       = pick_s ? req1_a   : req0_a;
                    op_b_d       = pick_s ? req1_b   : req0_b;
                    op_sel_d     = pick_s ? req1_sel : req0_sel;
                    id_d         = pick_s;
                    last_grant_d = pick_s;
                    state_d      = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                rsp_result_d = alu_out;
                rsp_carry_d  = alu_carry;
                rsp_id_d     = id_q;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_a_q       <= {DATA_W{1'b0}};
            op_b_q       <= {DATA_W{1'b0}};
            op_sel_q     <= {SEL_W{1'b0}};
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= {RES_W{1'b0}};
            rsp_carry_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_sel_q     <= op_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_a      = op_a_q;
    assign alu_b      = op_b_q;
    assign alu_sel    = op_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter with a stub ALU, a cycle-level reference model and a scoreboard.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] req0_sel, req1_sel;
    logic       req0_ready, req1_ready;
    logic [1:0] alu_a, alu_b;
    logic [3:0] alu_sel;
    logic [6:0] alu_out;
    logic       alu_carry;
    logic       rsp_valid, rsp_id, rsp_carry, rsp_ready, busy;
    logic [6:0] rsp_result;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: whether a job is in flight, when its response appears, who was granted last.
    int         cyc = 0;
    bit         m_pend = 1'b0;
    int         m_resp_cyc = 0;
    bit         m_lg = 1'b1;
    logic [1:0] m_a = 2'b00, m_b = 2'b00;
    logic [3:0] m_sel = 4'b0000;
    logic [8:0] sbq[$];

    always #5 clk = ~clk;

    assign alu_out   = {alu_sel[2:0], alu_a, alu_b};
    assign alu_carry = alu_sel[3];

    alu_arbiter #(.DATA_W(2), .SEL_W(4), .RES_W(7)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel), .req1_ready(req1_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive at the falling edge, check against the model, then advance the model.
    task automatic step(input bit rst, input bit v0, input logic [1:0] a0, input logic [1:0] b0,
                        input logic [3:0] s0, input bit v1, input logic [1:0] a1, input logic [1:0] b1,
                        input logic [3:0] s1, input bit rr);
        bit any_v, win, acc;
        @(negedge clk);
        reset = rst; rsp_ready = rst ? 1'b0 : rr;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = s0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = s1;
        #1;
        any_v = v0 | v1;
        win   = (v0 && v1) ? !m_lg : v1;
        acc   = !rst && !m_pend && any_v;
        chk("req0_ready", req0_ready, acc && !win);
        chk("req1_ready", req1_ready, acc && win);
        chk("ready_onehot", req0_ready & req1_ready, 0);
        chk("busy", busy, m_pend);
        chk("rsp_valid", rsp_valid, m_pend && (cyc >= m_resp_cyc));
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_sel", alu_sel, m_sel);
        if (rst) begin
            m_pend = 1'b0; m_lg = 1'b1; m_a = 2'b00; m_b = 2'b00; m_sel = 4'b0000;
            sbq.delete();
        end else if (acc) begin
            m_a   = win ? a1 : a0;
            m_b   = win ? b1 : b0;
            m_sel = win ? s1 : s0;
            m_lg  = win;
            m_pend = 1'b1;
            m_resp_cyc = cyc + 2;
            sbq.push_back({win, m_sel[2:0], m_a, m_b, m_sel[3]});
        end else if (m_pend && cyc >= m_resp_cyc && rr) begin
            m_pend = 1'b0;
        end
        cyc++;
    endtask

    task automatic idle(input bit rr);
        step(1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 2'b00, 2'b00, 4'b0000, rr);
    endtask

    // Monitor: each completed response transfer is compared against the oldest expected entry.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL sb_unexpected: response id %0d result %0h with nothing expected", rsp_id, rsp_result);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_id", rsp_id, e[8]);
                    chk("rsp_result", rsp_result, e[7:1]);
                    chk("rsp_carry", rsp_carry, e[0]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 2'b00; req0_b = 2'b00; req0_sel = 4'b0000;
        req1_valid = 1'b1; req1_a = 2'b00; req1_b = 2'b00; req1_sel = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_carry", rsp_carry, 0);
        chk("rst_alu_sel", alu_sel, 0);

        // Single request.
        step(1'b0, 1'b1, 2'b10, 2'b01, 4'b1011, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("single_result", rsp_result, 7'b0111001);
        chk("single_carry", rsp_carry, 1'b1);
        chk("single_id", rsp_id, 1'b0);
        idle(1'b1);

        // Contention right after reset: requester 0 first, requester 1 three cycles later.
        step(1'b1, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0);
        step(1'b0, 1'b1, 2'b00, 2'b11, 4'b1111, 1'b1, 2'b01, 2'b11, 4'b1010, 1'b1);
        chk("cont_first_grant", req0_ready, 1'b1);
        step(1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b1, 2'b01, 2'b11, 4'b1010, 1'b1);
        step(1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b1, 2'b01, 2'b11, 4'b1010, 1'b1);
        chk("cont_result0", rsp_result, 7'b1110011);
        step(1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b1, 2'b01, 2'b11, 4'b1010, 1'b1);
        chk("cont_second_grant", req1_ready, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("cont_result1", rsp_result, 7'b0100111);
        chk("cont_id1", rsp_id, 1'b1);
        idle(1'b1);

        // Fairness with both requesters held valid.
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 2'($urandom), 2'($urandom), 4'($urandom),
                 1'b1, 2'($urandom), 2'($urandom), 4'($urandom), 1'b1);
        end
        repeat (3) idle(1'b1);

        // Backpressure on requester 1's response.
        step(1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b1, 2'b11, 2'b01, 4'b0011, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 2'b01, 2'b01, 4'b0101, 1'b1, 2'b10, 2'b10, 4'b1100, 1'b0);
            chk("bp_result", rsp_result, 7'b0111101);
            chk("bp_id", rsp_id, 1'b1);
            chk("bp_busy", busy, 1'b1);
        end
        idle(1'b1);

        // Idle: operands stay where the last accept left them.
        for (int i = 0; i < 10; i++) begin
            idle(1'b1);
        end
        chk("idle_alu_sel", alu_sel, 4'b0011);

        // Reset while the accepted operation is in EXEC.
        step(1'b0, 1'b1, 2'b01, 2'b10, 4'b1110, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b1);
        step(1'b1, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b1);
        idle(1'b1);
        chk("rexec_rsp_valid", rsp_valid, 1'b0);
        chk("rexec_rsp_result", rsp_result, 7'b0000000);
        chk("rexec_alu_sel", alu_sel, 4'b0000);
        repeat (4) idle(1'b1);

        // Randomized traffic with occasional resets and response backpressure.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 1) == 1), 2'($urandom), 2'($urandom), 4'($urandom),
                 ($urandom_range(0, 1) == 1), 2'($urandom), 2'($urandom), 4'($urandom),
                 ($urandom_range(0, 9) < 7));
        end
        repeat (5) idle(1'b1);
        chk("sb_drained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
